// File: rtl/matrix_entry_ctrl_pkg.sv
// matrix_entry_ctrl_pkg: shared state encoding, key codes and default sizes
package matrix_entry_ctrl_pkg;
    localparam int DEF_ELEM_WIDTH      = 12;
    localparam int DEF_NUM_SAMPLES     = 3;
    localparam int DEF_NUM_FEATURES    = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam logic [3:0] KEY_CLEAR = 4'hC;
    localparam logic [3:0] KEY_GO    = 4'hD;
    localparam logic [3:0] KEY_ENTER = 4'hE;
    typedef enum logic [2:0] {
        ST_ENTER_X    = 3'd0,
        ST_ENTER_Y    = 3'd1,
        ST_WAIT_GO    = 3'd2,
        ST_WAIT_READY = 3'd3,
        ST_RUN        = 3'd4,
        ST_RESULT     = 3'd5,
        ST_ERROR      = 3'd6
    } state_t;
endpackage

// File: rtl/matrix_entry_ctrl_key_press_detect.sv
// key_press_detect: one press pulse after key_down is stable for DEBOUNCE_CYCLES edges
module key_press_detect
    import matrix_entry_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic key_down,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] r_count;
    logic          r_armed;
    // Pulse is high during the cycle whose closing edge is the last required high sample
    assign press = key_down && r_armed && (r_count == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (!key_down) begin
            r_count <= '0;
            r_armed <= 1'b1;
        end else if (press) begin
            r_count <= '0;
            r_armed <= 1'b0;
        end else if (r_armed) begin
            r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: rtl/matrix_entry_ctrl.sv
// matrix_entry_ctrl: keypad entry of an X matrix and y vector, then datapath start/result handshake
module matrix_entry_ctrl
    import matrix_entry_ctrl_pkg::*;
#(
    parameter int ELEM_WIDTH      = DEF_ELEM_WIDTH,
    parameter int NUM_SAMPLES     = DEF_NUM_SAMPLES,
    parameter int NUM_FEATURES    = DEF_NUM_FEATURES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [3:0]                                   key_code,
    input  logic                                         key_down,
    input  logic                                         dp_ready,
    input  logic                                         dp_done,
    input  logic                                         dp_error,
    output logic [NUM_SAMPLES*NUM_FEATURES*ELEM_WIDTH-1:0] X_in,
    output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]            y_in,
    output logic                                         dp_start,
    output logic [ELEM_WIDTH-1:0]                        cur_value,
    output logic [3:0]                                   elem_idx,
    output logic [2:0]                                   phase,
    output logic                                         err
);
    localparam int NX = NUM_SAMPLES * NUM_FEATURES;
    localparam int MW = ELEM_WIDTH + 4;

    state_t                     r_state, w_state_nxt;
    logic [NX*ELEM_WIDTH-1:0]   r_x, w_x_nxt;
    logic [NUM_SAMPLES*ELEM_WIDTH-1:0] r_y, w_y_nxt;
    logic [ELEM_WIDTH-1:0]      r_cur, w_cur_nxt, w_sat;
    logic [3:0]                 r_idx, w_idx_nxt;
    logic                       r_start, w_start_nxt;
    logic                       w_press, w_clear;
    logic [MW-1:0]              w_mul;

    key_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_kpd (
        .clock   (clock),
        .reset   (reset),
        .key_down(key_down),
        .press   (w_press)
    );

    // Widened so that any 4-digit overflow is visible in the top nibble
    assign w_mul = {4'd0, r_cur} * MW'(10) + MW'(key_code);
    assign w_sat = |w_mul[MW-1:ELEM_WIDTH] ? '1 : w_mul[ELEM_WIDTH-1:0];
    assign w_clear = w_press && key_code == KEY_CLEAR &&
                     (r_state == ST_WAIT_GO || r_state == ST_RESULT || r_state == ST_ERROR);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_cur_nxt   = r_cur;
        w_idx_nxt   = r_idx;
        w_start_nxt = 1'b0;
        case (r_state)
            ST_ENTER_X, ST_ENTER_Y: begin
                if (w_press && key_code <= 4'd9) begin
                    w_cur_nxt = w_sat;
                end else if (w_press && key_code == KEY_CLEAR) begin
                    w_cur_nxt = '0;
                end else if (w_press && key_code == KEY_ENTER) begin
                    w_cur_nxt = '0;
                    w_idx_nxt = r_idx + 4'd1;
                    for (int k = 0; k < NX; k++)
                        if (r_state == ST_ENTER_X && r_idx == 4'(k))
                            w_x_nxt[k*ELEM_WIDTH +: ELEM_WIDTH] = r_cur;
                    for (int k = 0; k < NUM_SAMPLES; k++)
                        if (r_state == ST_ENTER_Y && r_idx == 4'(k))
                            w_y_nxt[k*ELEM_WIDTH +: ELEM_WIDTH] = r_cur;
                    if (r_state == ST_ENTER_X && r_idx == 4'(NX - 1)) begin
                        w_state_nxt = ST_ENTER_Y;
                        w_idx_nxt   = '0;
                    end
                    if (r_state == ST_ENTER_Y && r_idx == 4'(NUM_SAMPLES - 1))
                        w_state_nxt = ST_WAIT_GO;
                end
            end
            ST_WAIT_GO: begin
                if (w_press && key_code == KEY_GO)
                    w_state_nxt = ST_WAIT_READY;
            end
            ST_WAIT_READY: begin
                if (dp_ready) begin
                    w_start_nxt = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = dp_error ? ST_ERROR : dp_done ? ST_RESULT : ST_RUN;
            end
            default: ;
        endcase
        if (w_clear) begin
            w_state_nxt = ST_ENTER_X;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_cur_nxt   = '0;
            w_idx_nxt   = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_ENTER_X;
            r_x     <= '0;
            r_y     <= '0;
            r_cur   <= '0;
            r_idx   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_cur   <= w_cur_nxt;
            r_idx   <= w_idx_nxt;
            r_start <= w_start_nxt;
        end
    end

    assign X_in      = r_x;
    assign y_in      = r_y;
    assign dp_start  = r_start;
    assign cur_value = r_cur;
    assign elem_idx  = r_idx;
    assign phase     = r_state;
    assign err       = (r_state == ST_ERROR);
endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// tb_matrix_entry_ctrl: directed keypad sequences with hand-computed expectations
module tb_matrix_entry_ctrl;
    import matrix_entry_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_code = 4'h0;
    logic        key_down = 1'b0;
    logic        dp_ready = 1'b0;
    logic        dp_done = 1'b0;
    logic        dp_error = 1'b0;
    logic [71:0] X_in;
    logic [35:0] y_in;
    logic        dp_start;
    logic [11:0] cur_value;
    logic [3:0]  elem_idx;
    logic [2:0]  phase;
    logic        err;
    int          n_chk = 0;
    int          n_pass = 0;

    matrix_entry_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .key_code (key_code),
        .key_down (key_down),
        .dp_ready (dp_ready),
        .dp_done  (dp_done),
        .dp_error (dp_error),
        .X_in     (X_in),
        .y_in     (y_in),
        .dp_start (dp_start),
        .cur_value(cur_value),
        .elem_idx (elem_idx),
        .phase    (phase),
        .err      (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    task automatic hold(input logic [3:0] c, input int n);
        @(negedge clock);
        key_code = c;
        key_down = 1'b1;
        repeat (n) @(negedge clock);
        key_down = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic press(input logic [3:0] c);
        hold(c, 16);
    endtask

    task automatic start_run();
        press(KEY_GO);
        dp_ready = 1'b1;
        repeat (2) @(negedge clock);
        dp_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_phase", phase, 0);
        check("rst_cur", cur_value, 0);
        check("rst_idx", elem_idx, 0);
        check("rst_start", dp_start, 0);
        check("rst_err", err, 0);
        check("rst_xy", {X_in, y_in}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        hold(4'd7, 15);
        check("short_hold", cur_value, 0);
        hold(4'd7, 100);
        check("long_hold_once", cur_value, 7);
        press(KEY_CLEAR);
        check("clear_cur", cur_value, 0);
        check("clear_idx", elem_idx, 0);

        press(4'd1); press(4'd2); press(4'd3);
        check("typed_123", cur_value, 123);
        press(KEY_ENTER);
        press(4'd4); press(4'd5); press(KEY_ENTER);
        check("x01", X_in[23:0], {12'd45, 12'd123});
        check("idx2", elem_idx, 2);
        press(4'd9); press(4'd9); press(4'd9);
        check("typed_999", cur_value, 999);
        press(4'd9);
        check("saturate", cur_value, 4095);
        press(KEY_ENTER);
        check("x2_sat", X_in[35:24], 4095);
        press(4'd5); press(KEY_CLEAR);
        check("c_mid", cur_value, 0);
        check("c_keeps_idx", elem_idx, 3);
        press(4'd8); press(KEY_ENTER);
        check("x3", X_in[47:36], 8);
        press(KEY_GO); press(4'hA); press(4'hF);
        check("d_ignored_phase", phase, 0);
        check("d_ignored_idx", elem_idx, 4);
        check("abf_cur", cur_value, 0);
        press(KEY_ENTER);
        press(4'd2); press(KEY_ENTER);
        check("to_enter_y", phase, 1);
        check("y_idx0", elem_idx, 0);
        press(4'd1); press(KEY_ENTER);
        press(4'd2); press(KEY_ENTER);
        press(4'd3); press(KEY_ENTER);
        check("wait_go", phase, 2);
        check("x_all", X_in, {12'd2, 12'd0, 12'd8, 12'd4095, 12'd45, 12'd123});
        check("y_all", y_in, {12'd3, 12'd2, 12'd1});
        press(4'd5);
        check("wg_digit_ign", cur_value, 0);
        press(KEY_GO);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("wait_ready", phase, 3);
            check("no_start", dp_start, 0);
        end
        dp_ready = 1'b1;
        @(negedge clock);
        check("start_pulse", dp_start, 1);
        check("run", phase, 4);
        dp_ready = 1'b0;
        @(negedge clock);
        check("start_once", dp_start, 0);
        press(KEY_CLEAR);
        check("run_ign_c", phase, 4);
        check("run_x_held", X_in, {12'd2, 12'd0, 12'd8, 12'd4095, 12'd45, 12'd123});
        dp_done = 1'b1; dp_error = 1'b1;
        @(negedge clock);
        dp_done = 1'b0; dp_error = 1'b0;
        check("both_error", phase, 6);
        check("err_flag", err, 1);
        check("error_start", dp_start, 0);
        press(KEY_GO);
        check("err_ign_d", phase, 6);
        check("err_y_held", y_in, {12'd3, 12'd2, 12'd1});
        press(KEY_CLEAR);
        check("err_clear_phase", phase, 0);
        check("err_clear_xy", {X_in, y_in}, 0);
        check("err_clear_err", err, 0);

        press(4'd4);
        repeat (9) press(KEY_ENTER);
        start_run();
        check("run2", phase, 4);
        dp_done = 1'b1;
        @(negedge clock);
        dp_done = 1'b0;
        check("result", phase, 5);
        check("result_err", err, 0);
        check("result_x", X_in, 72'd4);
        press(KEY_CLEAR);
        check("res_clear", {X_in, y_in, 1'b0, phase}, 0);

        press(4'd6);
        repeat (9) press(KEY_ENTER);
        start_run();
        check("run3_x", X_in, 72'd6);
        @(negedge clock);
        key_code = 4'd7;
        key_down = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("async_rst_phase", phase, 0);
        check("async_rst_all", {X_in, y_in, cur_value, elem_idx, dp_start, err}, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("held_no_press", cur_value, 0);
        key_down = 1'b0;
        repeat (2) @(negedge clock);
        press(4'd7);
        check("repress", cur_value, 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
